oric_tap_player: RTL and testbench

- Plays a TAP image, already loaded into the tape buffer RAM by the "Load Tape" download path, back into the Oric core as a serial cassette waveform.
- Drives the core's K7_TAPEIN.
- Reads the buffer one byte at a time and frames each byte in Oric fast-format encoding: start bit, 8 data bits, parity, stop bits.
- Emits each bit as a timed high/low pulse pair.

---
 rtl/oric_tap_player.sv | 147 ++++++++++++++
 tb/tb_oric_tap_player.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oric_tap_player.sv
// Replays a TAP image from the tape buffer RAM as an Oric fast-format cassette waveform.
// Each byte is framed as start, 8 data bits (LSB first), odd parity and stop bits; each bit is a high/low pulse pair.
module oric_tap_player #(
  parameter int ADDR_W    = 16,
  parameter int T_SHORT   = 4992,
  parameter int T_LONG    = 9984,
  parameter int STOP_BITS = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              play,
  input  logic              stop,
  input  logic              pause,
  input  logic [ADDR_W-1:0] tape_len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic              tape_out,
  output logic              busy,
  output logic              done
);

  localparam int FRAME_W = 10 + STOP_BITS;
  localparam int CNT_W   = $clog2(T_LONG + 1);
  localparam int IDX_W   = $clog2(FRAME_W);

  localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(T_SHORT - 1);
  localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(T_LONG - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_HI    = 3'd3,
    S_LO    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_r;
  logic [ADDR_W-1:0]  len_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [IDX_W-1:0]   idx_r;
  logic [FRAME_W-1:0] frame_r;
  logic [ADDR_W-1:0]  addr_next_s;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  assign addr_next_s = mem_addr + ADDR_W'(1'b1);

  // Playback FSM: byte fetch, frame shifting, half-cycle timing and all registered outputs.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_r  <= S_IDLE;
      len_r    <= '0;
      cnt_r    <= '0;
      idx_r    <= '0;
      frame_r  <= '0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      tape_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (stop && (state_r != S_IDLE)) begin
      state_r  <= S_IDLE;
      mem_rd   <= 1'b0;
      tape_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          // stop in the same cycle cancels the request
          if (play && !stop) begin
            if (tape_len != '0) begin
              len_r    <= tape_len;
              mem_addr <= '0;
              mem_rd   <= 1'b1;
              busy     <= 1'b1;
              state_r  <= S_FETCH;
            end else begin
              done    <= 1'b1;
              state_r <= S_DONE;
            end
          end
        end
        S_FETCH: begin
          mem_rd  <= 1'b0;
          state_r <= S_LOAD;
        end
        S_LOAD: begin
          frame_r  <= {{STOP_BITS{1'b1}}, odd_parity(mem_data), mem_data, 1'b0};
          idx_r    <= '0;
          cnt_r    <= SHORT_LOAD;
          tape_out <= 1'b1;
          state_r  <= S_HI;
        end
        S_HI: begin
          if (!pause) begin
            if (cnt_r == '0) begin
              tape_out <= 1'b0;
              cnt_r    <= frame_r[0] ? SHORT_LOAD : LONG_LOAD;
              state_r  <= S_LO;
            end else begin
              cnt_r <= cnt_r - 1'b1;
            end
          end
        end
        S_LO: begin
          if (!pause) begin
            if (cnt_r != '0) begin
              cnt_r <= cnt_r - 1'b1;
            end else if (idx_r != LAST_IDX) begin
              idx_r    <= idx_r + 1'b1;
              frame_r  <= {1'b0, frame_r[FRAME_W-1:1]};
              cnt_r    <= SHORT_LOAD;
              tape_out <= 1'b1;
              state_r  <= S_HI;
            end else begin
              mem_addr <= addr_next_s;
              // termination on equality means the address never wraps
              if (addr_next_s == len_r) begin
                done    <= 1'b1;
                busy    <= 1'b0;
                state_r <= S_DONE;
              end else begin
                mem_rd  <= 1'b1;
                state_r <= S_FETCH;
              end
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oric_tap_player.sv
// Directed bench for oric_tap_player: table of tapes with hand-computed frames and done times,
// plus hand-written pause, stop, asynchronous reset and play-while-busy sequences.
module tb_oric_tap_player;

  localparam int TS = 4;
  localparam int TL = 8;
  localparam int SB = 4;
  localparam int MAXT = 700;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        play    = 1'b0;
  logic        stop    = 1'b0;
  logic        pause   = 1'b0;
  logic [15:0] tape_len = 16'd0;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        tape_out;
  logic        busy;
  logic        done;

  logic [7:0]  mem [0:15];

  typedef struct {
    int               n;
    logic [2:0][7:0]  bytes;
    logic [2:0][13:0] frames;
    int               exp_done;
  } vec_t;

  vec_t vecs [5];

  logic        tr_tape [0:MAXT-1];
  logic        tr_rd   [0:MAXT-1];
  logic [15:0] tr_addr [0:MAXT-1];
  logic        tr_busy [0:MAXT-1];
  logic        tr_done [0:MAXT-1];
  int          done_t;
  int          last_t;

  int tests = 0;
  int fails = 0;

  oric_tap_player #(
    .ADDR_W   (16),
    .T_SHORT  (TS),
    .T_LONG   (TL),
    .STOP_BITS(SB)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .play    (play),
    .stop    (stop),
    .pause   (pause),
    .tape_len(tape_len),
    .mem_addr(mem_addr),
    .mem_rd  (mem_rd),
    .mem_data(mem_data),
    .tape_out(tape_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk_sys = ~clk_sys;

  // Tape buffer RAM: data valid the cycle after the read strobe.
  always @(posedge clk_sys) begin
    if (mem_rd) mem_data <= mem[mem_addr[3:0]];
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [13:0] f0, input logic [13:0] f1,
                         input logic [13:0] f2, input int d);
    vecs[i].n        = n;
    vecs[i].bytes    = {b2, b1, b0};
    vecs[i].frames   = {f2, f1, f0};
    vecs[i].exp_done = d;
  endtask

  task automatic load(input int v);
    for (int i = 0; i < 3; i++) mem[i] = vecs[v].bytes[i];
    tape_len = 16'(vecs[v].n);
  endtask

  // Call at a falling edge; trace index t is the offset in cycles from the play cycle.
  task automatic capture(input int max_t, input int pause_at, input int pause_len,
                         input int stop_at, input int replay_at);
    done_t = -1;
    last_t = 0;
    play   = 1'b1;
    for (int t = 1; t <= max_t; t++) begin
      @(negedge clk_sys);
      tr_tape[t] = tape_out;
      tr_rd[t]   = mem_rd;
      tr_addr[t] = mem_addr;
      tr_busy[t] = busy;
      tr_done[t] = done;
      last_t     = t;
      if (done === 1'b1 && done_t < 0) done_t = t;
      play  = (t == replay_at) ? 1'b1 : 1'b0;
      pause = (t >= pause_at && t < pause_at + pause_len) ? 1'b1 : 1'b0;
      stop  = (t == stop_at) ? 1'b1 : 1'b0;
      if (done_t > 0 && t >= done_t + 4) break;
    end
    play  = 1'b0;
    pause = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic analyze(input int v);
    int n, rd_cnt, done_cnt, k, t, hi, lo, exp_lo, first_rise, endp;
    logic [13:0] fr;
    n = vecs[v].n;
    check($sformatf("v%0d done_time", v), done_t, vecs[v].exp_done);
    done_cnt = 0;
    rd_cnt   = 0;
    for (int i = 1; i <= last_t; i++) begin
      if (tr_done[i] === 1'b1) done_cnt++;
      if (tr_rd[i] === 1'b1) begin
        check($sformatf("v%0d rd_addr", v), int'(tr_addr[i]), rd_cnt);
        rd_cnt++;
      end
    end
    check($sformatf("v%0d done_pulses", v), done_cnt, 1);
    check($sformatf("v%0d rd_count", v), rd_cnt, n);
    check($sformatf("v%0d rd_at_c1", v), int'(tr_rd[1]), (n != 0) ? 1 : 0);
    check($sformatf("v%0d busy_at_c1", v), int'(tr_busy[1]), (n != 0) ? 1 : 0);
    if (done_t > 0) check($sformatf("v%0d busy_at_done", v), int'(tr_busy[done_t]), 0);
    endp = (done_t > 0) ? done_t : last_t + 1;
    k = 0;
    first_rise = 0;
    t = 1;
    while (t < endp) begin
      if (tr_tape[t] === 1'b1) begin
        if (k == 0) first_rise = t;
        hi = 0;
        while (t < endp && tr_tape[t] === 1'b1) begin hi++; t++; end
        lo = 0;
        while (t < endp && tr_tape[t] !== 1'b1) begin lo++; t++; end
        if (k < 14 * n) begin
          fr = vecs[v].frames[k / 14];
          exp_lo = ((fr[k % 14] == 1'b1) ? TS : TL) + ((k % 14 == 13 && k / 14 < n - 1) ? 2 : 0);
          check($sformatf("v%0d hi_len[%0d]", v, k), hi, TS);
          check($sformatf("v%0d lo_len[%0d]", v, k), lo, exp_lo);
        end
        k++;
      end else begin
        t++;
      end
    end
    check($sformatf("v%0d bit_count", v), k, 14 * n);
    check($sformatf("v%0d first_rise", v), first_rise, (n != 0) ? 3 : 0);
  endtask

  initial begin
    int hi, t, late;

    set_vec(0, 1, 8'h16, 8'h00, 8'h00, 14'h3C2C, 14'h0000, 14'h0000, 143);
    set_vec(1, 2, 8'hFF, 8'h00, 8'h00, 14'h3FFE, 14'h3E00, 14'h0000, 269);
    set_vec(2, 0, 8'h00, 8'h00, 8'h00, 14'h0000, 14'h0000, 14'h0000, 1);
    set_vec(3, 3, 8'h01, 8'h80, 8'hA5, 14'h3C02, 14'h3D00, 14'h3F4A, 435);
    set_vec(4, 1, 8'hA5, 8'h00, 8'h00, 14'h3F4A, 14'h0000, 14'h0000, 135);

    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    check("rst tape_out", int'(tape_out), 0);
    check("rst mem_rd", int'(mem_rd), 0);
    check("rst mem_addr", int'(mem_addr), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);

    for (int v = 0; v < 5; v++) begin
      load(v);
      capture(600, 0, 0, 0, 0);
      analyze(v);
      repeat (2) @(negedge clk_sys);
    end

    // play and stop together from IDLE: stop wins
    load(0);
    play = 1'b1;
    stop = 1'b1;
    @(negedge clk_sys);
    play = 1'b0;
    stop = 1'b0;
    check("play_stop busy", int'(busy), 0);
    check("play_stop mem_rd", int'(mem_rd), 0);
    @(negedge clk_sys);
    check("play_stop busy2", int'(busy), 0);
    check("play_stop done", int'(done), 0);

    // pause for 20 cycles inside the first HI
    load(0);
    capture(600, 4, 20, 0, 0);
    hi = 0;
    t = 3;
    while (t < last_t && tr_tape[t] === 1'b1) begin hi++; t++; end
    check("pause hi_len", hi, 24);
    check("pause done_time", done_t, 163);
    repeat (2) @(negedge clk_sys);

    // stop during bit 5 (its HI spans offsets 55..58)
    load(0);
    capture(200, 0, 0, 56, 0);
    check("stop tape_before", int'(tr_tape[56]), 1);
    check("stop tape_after", int'(tr_tape[57]), 0);
    check("stop busy_after", int'(tr_busy[57]), 0);
    check("stop no_done", done_t, -1);
    late = 0;
    for (int i = 57; i <= last_t; i++) if (tr_tape[i] === 1'b1) late++;
    check("stop tape_quiet", late, 0);
    load(0);
    capture(600, 0, 0, 0, 0);
    analyze(0);
    repeat (2) @(negedge clk_sys);

    // asynchronous reset during the LO of byte 1 of 3
    load(3);
    capture(160, 0, 0, 0, 0);
    check("arst busy_before", int'(tr_busy[160]), 1);
    check("arst addr_before", int'(tr_addr[160]), 1);
    #2 reset = 1'b1;
    #1;
    check("arst tape_out", int'(tape_out), 0);
    check("arst mem_rd", int'(mem_rd), 0);
    check("arst mem_addr", int'(mem_addr), 0);
    check("arst busy", int'(busy), 0);
    check("arst done", int'(done), 0);
    #1 reset = 1'b0;
    @(negedge clk_sys);
    load(3);
    capture(600, 0, 0, 0, 0);
    analyze(3);
    repeat (2) @(negedge clk_sys);

    // play pulsed again while busy must be ignored
    load(0);
    capture(600, 0, 0, 0, 50);
    analyze(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
